alu_iter_exec: RTL and testbench
================================

Name: alu_iter_exec

Overview:
- Execute-stage unit that consumes the 4-bit Operation code produced by the ALU operation decoder, together with two operands.
- Handles the logic, arithmetic, compare and branch-condition codes in one cycle.
- Performs shifts iteratively at one bit per cycle.
- Uses a valid/ready handshake on both sides so the datapath can stall while a shift is in progress.

Parameters:
- DATA_W, 32, operand/result width
- SHAMT_W, 5, shift-amount width; shift amount is SrcB[SHAMT_W-1:0]

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation/operands presented
- in_ready  out  1  unit can accept (high only in IDLE)
- Operation  in  4  operation code (encoding below)
- SrcA  in  DATA_W  operand A
- SrcB  in  DATA_W  operand B / shift amount
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- ALUResult  out  DATA_W  result
- BrTaken  out  1  branch condition true (branch codes only)
- Illegal  out  1  unassigned Operation code was accepted

Behaviour:
- Encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR
  - 1000 BEQ, 1001 BNE, 1010 BLT (signed), 1011 BGE (signed)
  - 1100 SLT (signed), 1101 SLL, 1110 SRL, 1111 SRA
  - 0101/0110/0111 unassigned
- States: IDLE, SHIFT, DONE.
- Reset: state=IDLE; ALUResult=0, BrTaken=0, Illegal=0, out_valid=0; in_ready=1 the cycle after reset.
- Accept: in_valid & in_ready at an edge. Operation, SrcA and SrcB are latched internally; inputs are don't-care afterwards.
- IDLE -> DONE (single-cycle ops, and shifts with shift amount 0):
  - Result registered at the accept edge; out_valid=1 the next cycle (latency 1).
- IDLE -> SHIFT (shifts with shift amount > 0):
  - Working register loaded with SrcA; down-counter loaded with the shift amount.
- SHIFT:
  - Each cycle: one-bit shift (SLL: <<1 zero-fill; SRL: >>1 zero-fill; SRA: >>1 sign-fill), counter decremented.
  - When the counter reaches 0 at an edge -> DONE.
  - Shift latency = 1 + shift amount cycles (shift amount 31 -> out_valid in the 32nd cycle after accept).
- DONE:
  - out_valid=1; ALUResult, BrTaken and Illegal held stable until out_valid & out_ready.
  - Handshake edge -> IDLE; out_valid=0 the next cycle.
  - No new accept while in SHIFT/DONE (in_ready=0); back-to-back throughput is 2 cycles per single-cycle op.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_W; no carry/overflow output.
  - SLT result = {0..., A<B signed}.
- Branch codes: ALUResult = SUB result (A-B); BrTaken = condition. BrTaken=0 for all non-branch codes.
- Unassigned codes: ALUResult=0, BrTaken=0, Illegal=1; latency 1.
- out_ready held high in DONE: handshake completes in the first DONE cycle.
- out_ready low: unit stalls indefinitely, outputs held.
- reset asserted in any state, including mid-shift or in DONE with a pending result:
  - Next cycle IDLE; all outputs cleared; the in-flight operation is dropped.
- in_valid while in_ready=0: ignored; the producer must hold it.

Test Plan:
- Reset then ADD A=0xFFFFFFFF B=0x00000001, out_ready=1 -> out_valid 1 cycle after accept, ALUResult=0x00000000, BrTaken=0, Illegal=0.
- SRA A=0x80000000 B=31 -> out_valid exactly 32 cycles after accept, ALUResult=0xFFFFFFFF; SRL same operands -> 0x00000001; SLL A=1 B=0 -> 0x00000001 at latency 1.
- BLT A=0xFFFFFFFE(-2) B=0x00000003 -> BrTaken=1, ALUResult=0xFFFFFFFB; BGE same -> BrTaken=0; BEQ A=B=0x1234 -> BrTaken=1, ALUResult=0.
- SLT A=0x00000005 B=0x80000000 -> ALUResult=0; hold out_ready=0 for 5 cycles -> out_valid and ALUResult stable, in_ready=0 throughout, then accepted on the first out_ready=1.
- Operation=0110 -> Illegal=1, ALUResult=0 at latency 1; following XOR A=0xF0F0F0F0 B=0xFFFF0000 -> ALUResult=0x0F0FF0F0, Illegal=0.
- SLL A=1 B=20, assert reset 7 cycles after accept -> next cycle out_valid=0, ALUResult=0, in_ready=1; a fresh OR A=0x0F B=0xF0 -> ALUResult=0xFF.

Source files
------------

// File: rtl/alu_iter_exec_if.sv
// alu_iter_exec_if: operand/result valid-ready bus between the decoder stage, the execute unit and its consumer.
interface alu_iter_exec_if #(parameter int DATA_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        Operation;
    logic [DATA_W-1:0] SrcA;
    logic [DATA_W-1:0] SrcB;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ALUResult;
    logic              BrTaken;
    logic              Illegal;
    modport master (output in_valid, Operation, SrcA, SrcB, out_ready,
                    input in_ready, out_valid, ALUResult, BrTaken, Illegal);
    modport slave (input in_valid, Operation, SrcA, SrcB, out_ready,
                   output in_ready, out_valid, ALUResult, BrTaken, Illegal);
endinterface

// File: rtl/alu_iter_exec.sv
// alu_iter_exec: execute stage with single-cycle logic/arith/compare/branch ops and bit-serial shifts.
module alu_iter_exec #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input logic           clk,
    input logic           reset,
    alu_iter_exec_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t             state_q;
    logic [DATA_W-1:0]  res_q, res_d, shf_d, a, b, diff;
    logic               br_q, br_d, ill_q, ill_d, lt, is_shift;
    logic [1:0]         sop_q;
    logic [SHAMT_W-1:0] cnt_q, shamt;
    always_comb begin
        a        = bus.SrcA;
        b        = bus.SrcB;
        diff     = a - b;
        lt       = $signed(a) < $signed(b);
        shamt    = b[SHAMT_W-1:0];
        is_shift = bus.Operation[3:2] == 2'b11 && bus.Operation[1:0] != 2'b00;
        res_d    = '0;
        br_d     = 1'b0;
        ill_d    = 1'b0;
        case (bus.Operation)
            4'b0000: res_d = a & b;
            4'b0001: res_d = a | b;
            4'b0010: res_d = a + b;
            4'b0011: res_d = diff;
            4'b0100: res_d = a ^ b;
            4'b1000: begin res_d = diff; br_d = diff == '0; end
            4'b1001: begin res_d = diff; br_d = diff != '0; end
            4'b1010: begin res_d = diff; br_d = lt; end
            4'b1011: begin res_d = diff; br_d = !lt; end
            4'b1100: res_d = {{(DATA_W-1){1'b0}}, lt};
            4'b1101, 4'b1110, 4'b1111: res_d = a;
            default: ill_d = 1'b1;
        endcase
        // sop_q: 01 SLL, 10 SRL, 11 SRA; bit 0 selects sign fill for right shifts
        shf_d = sop_q == 2'b01 ? {res_q[DATA_W-2:0], 1'b0}
                               : {sop_q[0] & res_q[DATA_W-1], res_q[DATA_W-1:1]};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
            sop_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    res_q   <= res_d;
                    br_q    <= br_d;
                    ill_q   <= ill_d;
                    sop_q   <= bus.Operation[1:0];
                    cnt_q   <= shamt;
                    state_q <= (is_shift && shamt != '0) ? SHIFT : DONE;
                end
                SHIFT: begin
                    res_q <= shf_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == SHAMT_W'(1)) state_q <= DONE;
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.ALUResult = res_q;
    assign bus.BrTaken   = br_q;
    assign bus.Illegal   = ill_q;
endmodule

// File: tb/tb_alu_iter_exec.sv
// tb_alu_iter_exec: directed plus random operations checked against an arithmetic reference model.
module tb_alu_iter_exec;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    always #5 clk = ~clk;
    alu_iter_exec_if #(.DATA_W(32)) bus();
    alu_iter_exec #(.DATA_W(32), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic br, output logic ill, output int lat);
        int sh = int'(b[4:0]);
        logic signed [31:0] sa = a;
        logic signed [31:0] sb = b;
        r = 0; br = 0; ill = 0; lat = 1;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = a + b;
            3: r = a - b;
            4: r = a ^ b;
            8: begin r = a - b; br = a == b; end
            9: begin r = a - b; br = a != b; end
            10: begin r = a - b; br = sa < sb; end
            11: begin r = a - b; br = sa >= sb; end
            12: r = (sa < sb) ? 32'd1 : 32'd0;
            13: r = a << sh;
            14: r = a >> sh;
            15: r = sa >>> sh;
            default: ill = 1;
        endcase
        if (op >= 13) lat = 1 + sh;
    endfunction
    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [31:0] er;
        logic eb, ei;
        int el, lat;
        model(op, a, b, er, eb, ei, el);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.Operation = op;
        bus.SrcA = a;
        bus.SrcB = b;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.Operation = 4'($urandom);
        bus.SrcA = $urandom;
        bus.SrcB = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 40);
        chk("latency", 32'(lat), 32'(el));
        chk("result", bus.ALUResult, er);
        chk("br_taken", 32'(bus.BrTaken), 32'(eb));
        chk("illegal", 32'(bus.Illegal), 32'(ei));
        if (!bus.out_valid) begin
            do_reset();
            return;
        end
        if (stall > 0) begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                chk("stall_valid", 32'(bus.out_valid), 1);
                chk("stall_result", bus.ALUResult, er);
                chk("stall_in_ready", 32'(bus.in_ready), 0);
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk("valid_drop", 32'(bus.out_valid), 0);
        chk("in_ready_back", 32'(bus.in_ready), 1);
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.Operation = 4'd0;
        bus.SrcA = '0;
        bus.SrcB = '0;
        do_reset();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_result", bus.ALUResult, 0);
        chk("rst_br", 32'(bus.BrTaken), 0);
        chk("rst_illegal", 32'(bus.Illegal), 0);
        run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(4'b1111, 32'h8000_0000, 32'd31, 0);
        run_op(4'b1110, 32'h8000_0000, 32'd31, 0);
        run_op(4'b1101, 32'h0000_0001, 32'd0, 0);
        run_op(4'b1010, 32'hFFFF_FFFE, 32'h0000_0003, 0);
        run_op(4'b1011, 32'hFFFF_FFFE, 32'h0000_0003, 0);
        run_op(4'b1000, 32'h0000_1234, 32'h0000_1234, 0);
        run_op(4'b1100, 32'h0000_0005, 32'h8000_0000, 5);
        run_op(4'b0110, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op(4'b0100, 32'hF0F0_F0F0, 32'hFFFF_0000, 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.Operation = 4'b1101;
        bus.SrcA = 32'd1;
        bus.SrcB = 32'd20;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("midshift_valid", 32'(bus.out_valid), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_result", bus.ALUResult, 0);
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        chk("abort_illegal", 32'(bus.Illegal), 0);
        run_op(4'b0001, 32'h0000_000F, 32'h0000_00F0, 0);
        for (int n = 0; n < 30; n++)
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 2));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
